// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// writeback_queue : in-order writeback queue with split-phase load fill,
//                   load alignment/extension and a registered RF write port.
// Revision: 1.0
// ============================================================================
module writeback_queue #(
  parameter int REGISTER_WIDTH = 32,
  parameter int REGISTER_DEPTH = 32,
  parameter int QUEUE_DEPTH    = 4,
  localparam int AW = $clog2(REGISTER_DEPTH),
  localparam int OW = $clog2(REGISTER_WIDTH / 8)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_tvalid,
  output logic                      in_tready,
  input  logic [6:0]                in_opcode,
  input  logic [2:0]                in_funct3,
  input  logic [AW-1:0]             in_rd,
  input  logic [REGISTER_WIDTH-1:0] in_alu_result,
  input  logic [REGISTER_WIDTH-1:0] in_branch_target,
  input  logic [OW-1:0]             in_byte_offset,
  input  logic                      mem_rvalid,
  input  logic [REGISTER_WIDTH-1:0] mem_rdata,
  output logic                      reg_write_enable,
  output logic [AW-1:0]             reg_write_address,
  output logic [REGISTER_WIDTH-1:0] reg_write_data,
  output logic [31:0]               retire_count,
  output logic                      resp_error
);
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] C_FULL = CW'(QUEUE_DEPTH);

  localparam logic [6:0] OP_ARITHMETIC           = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_IMMEDIATE = 7'b0010011;
  localparam logic [6:0] OP_JALR                 = 7'b1100111;
  localparam logic [6:0] OP_LUI                  = 7'b0110111;
  localparam logic [6:0] OP_AUIPC                = 7'b0010111;
  localparam logic [6:0] OP_JAL                  = 7'b1101111;
  localparam logic [6:0] OP_LOAD                 = 7'b0000011;

  // Entry storage
  logic                      writes_q  [QUEUE_DEPTH];
  logic                      writes_d  [QUEUE_DEPTH];
  logic                      is_load_q [QUEUE_DEPTH];
  logic                      is_load_d [QUEUE_DEPTH];
  logic                      done_q    [QUEUE_DEPTH];
  logic                      done_d    [QUEUE_DEPTH];
  logic [AW-1:0]             rd_q      [QUEUE_DEPTH];
  logic [AW-1:0]             rd_d      [QUEUE_DEPTH];
  logic [REGISTER_WIDTH-1:0] result_q  [QUEUE_DEPTH];
  logic [REGISTER_WIDTH-1:0] result_d  [QUEUE_DEPTH];
  logic [2:0]                funct3_q  [QUEUE_DEPTH];
  logic [2:0]                funct3_d  [QUEUE_DEPTH];
  logic [OW-1:0]             offset_q  [QUEUE_DEPTH];
  logic [OW-1:0]             offset_d  [QUEUE_DEPTH];

  logic [QW-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      we_q, we_d;
  logic [AW-1:0]             waddr_q, waddr_d;
  logic [REGISTER_WIDTH-1:0] wdata_q, wdata_d;
  logic [31:0]               retire_count_q, retire_count_d;
  logic                      resp_error_q, resp_error_d;

  logic                      accept, retire, fill, fill_found;
  logic [QW-1:0]             fill_idx, scan_idx;
  logic [REGISTER_WIDTH-1:0] shifted, aligned;

  assign in_tready         = !rst && (count_q < C_FULL);
  assign reg_write_enable  = we_q;
  assign reg_write_address = waddr_q;
  assign reg_write_data    = wdata_q;
  assign retire_count      = retire_count_q;
  assign resp_error        = resp_error_q;

  // Fill pointer: oldest occupied load still waiting for data.
  always_comb begin
    fill_found = 1'b0;
    fill_idx   = head_q;
    scan_idx   = head_q;
    for (int i = QUEUE_DEPTH - 1; i >= 0; i--) begin
      scan_idx = head_q + QW'(i);
      if ((CW'(i) < count_q) && is_load_q[scan_idx] && !done_q[scan_idx]) begin
        fill_found = 1'b1;
        fill_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    shifted = mem_rdata >> {offset_q[fill_idx], 3'b000};
    case (funct3_q[fill_idx])
      3'b000:  aligned = REGISTER_WIDTH'($signed(shifted[7:0]));
      3'b100:  aligned = REGISTER_WIDTH'(shifted[7:0]);
      3'b001:  aligned = REGISTER_WIDTH'($signed(shifted[15:0]));
      3'b101:  aligned = REGISTER_WIDTH'(shifted[15:0]);
      3'b010:  aligned = REGISTER_WIDTH'($signed(shifted[31:0]));
      3'b110:  aligned = (REGISTER_WIDTH == 64) ? REGISTER_WIDTH'(shifted[31:0])
                                                : REGISTER_WIDTH'($signed(shifted[31:0]));
      default: aligned = shifted;
    endcase
  end

  always_comb begin
    writes_d       = writes_q;
    is_load_d      = is_load_q;
    done_d         = done_q;
    rd_d           = rd_q;
    result_d       = result_q;
    funct3_d       = funct3_q;
    offset_d       = offset_q;
    we_d           = 1'b0;
    waddr_d        = waddr_q;
    wdata_d        = wdata_q;
    resp_error_d   = resp_error_q;

    accept = in_tvalid && in_tready;
    retire = (count_q != '0) && done_q[head_q];
    fill   = mem_rvalid && fill_found;

    head_d         = head_q + QW'(retire);
    tail_d         = tail_q + QW'(accept);
    count_d        = count_q + CW'(accept) - CW'(retire);
    retire_count_d = retire_count_q + 32'(retire);

    if (accept) begin
      writes_d[tail_q]  = 1'b1;
      is_load_d[tail_q] = 1'b0;
      done_d[tail_q]    = 1'b1;
      rd_d[tail_q]      = in_rd;
      result_d[tail_q]  = in_alu_result;
      funct3_d[tail_q]  = in_funct3;
      offset_d[tail_q]  = in_byte_offset;
      case (in_opcode)
        OP_ARITHMETIC, OP_ARITHMETIC_IMMEDIATE, OP_JALR, OP_LUI, OP_AUIPC: ;
        OP_JAL:  result_d[tail_q] = in_branch_target;
        OP_LOAD: begin
          is_load_d[tail_q] = 1'b1;
          done_d[tail_q]    = 1'b0;
        end
        default: writes_d[tail_q] = 1'b0;
      endcase
    end

    // A fill never lands on the tail slot: accept requires a free slot.
    if (fill) begin
      result_d[fill_idx] = aligned;
      done_d[fill_idx]   = 1'b1;
    end else if (mem_rvalid) begin
      resp_error_d = 1'b1;
    end

    if (retire && writes_q[head_q] && (rd_q[head_q] != '0)) begin
      we_d    = 1'b1;
      waddr_d = rd_q[head_q];
      wdata_d = result_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      we_q           <= 1'b0;
      waddr_q        <= '0;
      wdata_q        <= '0;
      retire_count_q <= '0;
      resp_error_q   <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      we_q           <= we_d;
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
      retire_count_q <= retire_count_d;
      resp_error_q   <= resp_error_d;
    end
  end

  // Payload needs no reset; occupancy is governed by count_q alone.
  always_ff @(posedge clk) begin
    writes_q  <= writes_d;
    is_load_q <= is_load_d;
    done_q    <= done_d;
    rd_q      <= rd_d;
    result_q  <= result_d;
    funct3_q  <= funct3_d;
    offset_q  <= offset_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// ============================================================================
// tb_writeback_queue : directed plus randomized bench with a queue-level model.
// Revision: 1.0
// ============================================================================
module tb_writeback_queue;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_branch_target = '0;
  logic [1:0]  in_byte_offset = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        reg_write_enable;
  logic [4:0]  reg_write_address;
  logic [31:0] reg_write_data;
  logic [31:0] retire_count;
  logic        resp_error;

  always #5 clk = ~clk;

  writeback_queue #(.REGISTER_WIDTH(32), .REGISTER_DEPTH(32), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_branch_target(in_branch_target),
    .in_byte_offset(in_byte_offset), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .reg_write_enable(reg_write_enable), .reg_write_address(reg_write_address),
    .reg_write_data(reg_write_data), .retire_count(retire_count), .resp_error(resp_error)
  );

  typedef struct {
    bit          writes;
    bit          is_load;
    bit          done;
    int          rd;
    logic [31:0] val;
    int          f3;
    int          off;
  } ent_t;

  ent_t        mq[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_cnt = '0;
  logic        m_err = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  int          wlog_a[$];
  logic [31:0] wlog_d[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result from the byte/half/word rules, done in plain integer arithmetic.
  function automatic logic [31:0] load_value(input logic [31:0] word, input int f3, input int off);
    longint w;
    longint v;
    w = longint'(word) / (longint'(1) << (8 * off));
    case (f3)
      0: begin v = w % 256;   if (v >= 128)   v = v - 256;   end
      4: v = w % 256;
      1: begin v = w % 65536; if (v >= 32768) v = v - 65536; end
      5: v = w % 65536;
      default: v = w;
    endcase
    return v[31:0];
  endfunction

  function automatic int pending_loads();
    int n = 0;
    foreach (mq[i]) if (mq[i].is_load && !mq[i].done) n++;
    return n;
  endfunction

  // Reference model: advances once per rising edge from the inputs held across it.
  always @(posedge clk) begin : model
    int   fidx;
    bit   ret;
    bit   acc;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_we = 0; m_addr = 0; m_data = 0; m_cnt = 0; m_err = 0;
    end else begin
      fidx = -1;
      foreach (mq[i]) if (fidx < 0 && mq[i].is_load && !mq[i].done) fidx = i;
      ret = (mq.size() > 0) && mq[0].done;
      acc = in_tvalid && (mq.size() < QD);
      if (mem_rvalid) begin
        if (fidx >= 0) begin
          mq[fidx].val  = load_value(mem_rdata, mq[fidx].f3, mq[fidx].off);
          mq[fidx].done = 1;
        end else begin
          m_err = 1;
        end
      end
      m_we = 0;
      if (ret) begin
        e = mq.pop_front();
        m_cnt = m_cnt + 1;
        if (e.writes && e.rd != 0) begin
          m_we = 1; m_addr = e.rd[4:0]; m_data = e.val;
        end
      end
      if (acc) begin
        e.writes = 1; e.is_load = 0; e.done = 1; e.rd = in_rd;
        e.val = in_alu_result; e.f3 = in_funct3; e.off = in_byte_offset;
        case (in_opcode)
          7'b0110011, 7'b0010011, 7'b1100111, 7'b0110111, 7'b0010111: ;
          7'b1101111: e.val = in_branch_target;
          7'b0000011: begin e.is_load = 1; e.done = 0; end
          default:    e.writes = 0;
        endcase
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    chk("we",     reg_write_enable, m_we);
    chk("addr",   reg_write_address, m_addr);
    chk("data",   reg_write_data, m_data);
    chk("count",  retire_count, m_cnt);
    chk("err",    resp_error, m_err);
    chk("tready", in_tready, !rst && (mq.size() < QD));
    if (reg_write_enable === 1'b1) begin
      wlog_a.push_back(int'(reg_write_address));
      wlog_d.push_back(reg_write_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [31:0] alu, input logic [31:0] bt, input logic [1:0] off);
    int n = 0;
    in_tvalid = 1; in_opcode = op; in_funct3 = f3; in_rd = rd;
    in_alu_result = alu; in_branch_target = bt; in_byte_offset = off;
    #1;
    while (!in_tready && n < 50) begin
      cyc(); #1; n++;
    end
    if (n >= 50) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_tready stayed %0b, required 1", in_tready);
    end
    cyc();
    in_tvalid = 0;
  endtask

  task automatic rvalid(input logic [31:0] d);
    mem_rvalid = 1; mem_rdata = d;
    cyc();
    mem_rvalid = 0;
  endtask

  localparam logic [6:0] ADD = 7'b0110011, LD = 7'b0000011, JAL = 7'b1101111;

  initial begin : stim
    int base;
    logic [6:0] ops [8];
    ops = '{7'b0110011, 7'b0010011, 7'b1100111, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b0000011, 7'b0100011};

    idle(3);
    #1;
    chk("rst_tready", in_tready, 0);
    chk("rst_we", reg_write_enable, 0);
    chk("rst_count", retire_count, 0);
    rst = 0;

    // Back-to-back ADDs
    base = wlog_a.size();
    send(ADD, 0, 1, 32'h11, 0, 0);
    send(ADD, 0, 2, 32'h22, 0, 0);
    send(ADD, 0, 3, 32'h33, 0, 0);
    idle(2);
    chk("add_nwrites", wlog_a.size() - base, 3);
    if (wlog_a.size() >= base + 3) begin
      chk("add_a0", wlog_a[base],   1); chk("add_d0", wlog_d[base],   32'h11);
      chk("add_a1", wlog_a[base+1], 2); chk("add_d1", wlog_d[base+1], 32'h22);
      chk("add_a2", wlog_a[base+2], 3); chk("add_d2", wlog_d[base+2], 32'h33);
    end
    chk("add_count", retire_count, 3);

    // Byte/half alignment and extension
    send(LD, 3'b000, 7, 0, 0, 3); rvalid(32'h80FF_0000); idle(2);
    chk("lb", reg_write_data, 32'hFFFF_FF80);
    send(LD, 3'b100, 7, 0, 0, 3); rvalid(32'h80FF_0000); idle(2);
    chk("lbu", reg_write_data, 32'h0000_0080);
    send(LD, 3'b101, 7, 0, 0, 2); rvalid(32'h80FF_0000); idle(2);
    chk("lhu", reg_write_data, 32'h0000_80FF);

    // ADD held behind a slow load
    base = wlog_a.size();
    send(LD, 3'b010, 5, 0, 0, 0);
    send(ADD, 0, 6, 32'h66, 0, 0);
    idle(3);
    chk("hold_nowrite", wlog_a.size() - base, 0);
    rvalid(32'hDEAD_BEEF);
    idle(3);
    chk("hold_n", wlog_a.size() - base, 2);
    if (wlog_a.size() >= base + 2) begin
      chk("hold_a0", wlog_a[base], 5);   chk("hold_d0", wlog_d[base], 32'hDEAD_BEEF);
      chk("hold_a1", wlog_a[base+1], 6); chk("hold_d1", wlog_d[base+1], 32'h66);
    end

    // Full queue backpressure
    for (int i = 0; i < 4; i++) send(LD, 3'b010, 5'(8 + i), 0, 0, 0);
    #1;
    chk("full_tready", in_tready, 0);
    rvalid(32'h1);
    #1;
    chk("full_tready_m", in_tready, 0);
    cyc(); #1;
    chk("free_tready", in_tready, 1);
    for (int i = 0; i < 3; i++) rvalid(32'h100 + i);
    idle(3);

    // JAL to x0 and stray read data
    base = wlog_a.size();
    send(JAL, 0, 0, 0, 32'h100, 0);
    idle(2);
    chk("jal_nowrite", wlog_a.size() - base, 0);
    chk("jal_count", retire_count, 13);
    chk("err_before", resp_error, 0);
    rvalid(32'hABCD);
    idle(1);
    chk("err_set", resp_error, 1);
    idle(3);
    chk("err_sticky", resp_error, 1);

    // Reset with loads outstanding
    send(LD, 3'b010, 9, 0, 0, 0);
    send(LD, 3'b010, 10, 0, 0, 0);
    rst = 1;
    cyc(); #1;
    chk("r_we", reg_write_enable, 0); chk("r_addr", reg_write_address, 0);
    chk("r_data", reg_write_data, 0); chk("r_count", retire_count, 0);
    chk("r_err", resp_error, 0);      chk("r_tready", in_tready, 0);
    rst = 0;
    base = wlog_a.size();
    rvalid(32'h55);
    idle(2);
    chk("post_err", resp_error, 1);
    chk("post_nowrite", wlog_a.size() - base, 0);

    // Randomized traffic
    rst = 1; cyc(); rst = 0;
    for (int c = 0; c < 4000; c++) begin
      in_tvalid        = $urandom_range(0, 3) != 0;
      in_opcode        = ops[$urandom_range(0, 7)];
      in_funct3        = 3'($urandom_range(0, 7));
      in_rd            = 5'($urandom_range(0, 31));
      in_alu_result    = $urandom;
      in_branch_target = $urandom;
      in_byte_offset   = 2'($urandom_range(0, 3));
      mem_rdata        = $urandom;
      if (pending_loads() > 0) mem_rvalid = $urandom_range(0, 2) == 0;
      else                     mem_rvalid = $urandom_range(0, 60) == 0;
      rst              = $urandom_range(0, 700) == 0;
      cyc();
    end
    in_tvalid = 0; mem_rvalid = 0; rst = 0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
